rob_mc: RTL and testbench

ROB_MC -- requirements
Module: rob_mc

---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_commit_sel.sv | 35 +++
 rtl/rob_mc.sv | 176 +++++++++++++++++
 tb/tb_rob_mc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared entry type and constants for the reorder buffer
package rob_pkg;

    localparam int ROB_N_DEF = 8;
    localparam int IDW       = $clog2(ROB_N_DEF);
    localparam logic [IDW-1:0] ROB_INV_ID = '1;

    // Storage widths of an entry; WORD_SIZE / REG_INDEX_SIZE of rob_mc must not exceed these
    localparam int ROB_WORD = 32;
    localparam int ROB_REG  = 5;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic                is_store;
        logic                exc;
        logic                itlb;
        logic [ROB_REG-1:0]  rd;
        logic [ROB_WORD-1:0] data;
        logic [ROB_WORD-1:0] pc;
        logic [ROB_WORD-1:0] vaddr;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// rtl/rob_commit_sel.sv - picks the in-order commit group starting at head
module rob_commit_sel #(
    parameter int CW = 2
) (
    input  logic [CW-1:0] valid_i,
    input  logic [CW-1:0] ready_i,
    input  logic [CW-1:0] store_i,
    input  logic [CW-1:0] exc_i,
    output logic [CW-1:0] take_o,
    output logic [2:0]    n_o,
    output logic          head_exc_o
);

    // Longest clean run from head: stops at the first not-ready, excepting or second store entry
    always_comb begin
        logic stop;
        logic seen_st;
        take_o  = '0;
        n_o     = '0;
        stop    = 1'b0;
        seen_st = 1'b0;
        for (int k = 0; k < CW; k++) begin
            if (!stop && valid_i[k] && ready_i[k] && !exc_i[k] && !(store_i[k] && seen_st)) begin
                take_o[k] = 1'b1;
                n_o       = n_o + 3'd1;
                if (store_i[k]) seen_st = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
    end

    assign head_exc_o = valid_i[0] & ready_i[0] & exc_i[0];

endmodule

// File: rtl/rob_mc.sv
// rtl/rob_mc.sv - multi-commit reorder buffer top; optional bypass read ports under ROB_BYPASS_EN
module rob_mc
    import rob_pkg::*;
#(
    parameter int N              = 8,
    parameter int WB_PORTS       = 3,
    parameter int COMMIT_WIDTH   = 2,
    parameter int WORD_SIZE      = 32,
    parameter int REG_INDEX_SIZE = 5,
    localparam int IW            = $clog2(N)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alloc_valid,
    input  logic                               alloc_is_store,
    input  logic [REG_INDEX_SIZE-1:0]          alloc_rd,
    input  logic                               alloc_exc,
    input  logic [WORD_SIZE-1:0]               alloc_pc,
    output logic [IW-1:0]                      alloc_id,
    output logic                               full,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  logic [WB_PORTS*IW-1:0]             wb_id,
    input  logic [WB_PORTS*WORD_SIZE-1:0]      wb_data,
    input  logic [WB_PORTS-1:0]                wb_exc,
    input  logic [WB_PORTS*WORD_SIZE-1:0]      wb_pc,
    input  logic [WB_PORTS*WORD_SIZE-1:0]      wb_vaddr,
    output logic [COMMIT_WIDTH-1:0]            cm_valid,
    output logic [COMMIT_WIDTH*REG_INDEX_SIZE-1:0] cm_rd,
    output logic [COMMIT_WIDTH*WORD_SIZE-1:0]  cm_data,
    output logic [COMMIT_WIDTH*IW-1:0]         cm_id,
    output logic                               sb_permit,
    output logic [IW-1:0]                      sb_id,
    output logic                               exception,
    output logic [WORD_SIZE-1:0]               ex_pc,
    output logic [WORD_SIZE-1:0]               ex_vaddr,
`ifdef ROB_BYPASS_EN
    input  logic [IW-1:0]                      rs1_id,
    input  logic [IW-1:0]                      rs2_id,
    output logic [WORD_SIZE-1:0]               byp1_data,
    output logic [WORD_SIZE-1:0]               byp2_data,
    output logic                               byp1_valid,
    output logic                               byp2_valid,
`endif
    output logic                               ex_itlb
);

    rob_entry_t              ent_q [N];
    rob_entry_t              ent_d [N];
    logic [IW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [IW:0]             cnt_q, cnt_d;
    logic                    alloc_acc;
    logic [IW-1:0]           slot_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] s_valid, s_ready, s_store, s_exc, take;
    logic [2:0]              grp_n;
    logic                    head_exc;

    assign full      = (cnt_q == (IW+1)'(N));
    assign alloc_acc = alloc_valid && !full;
    assign alloc_id  = alloc_acc ? tail_q : '1;

    // Window of the oldest COMMIT_WIDTH entries, oldest in slot 0
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slot_idx[k] = head_q + IW'(k);
            s_valid[k]  = ent_q[slot_idx[k]].valid;
            s_ready[k]  = ent_q[slot_idx[k]].ready;
            s_store[k]  = ent_q[slot_idx[k]].is_store;
            s_exc[k]    = ent_q[slot_idx[k]].exc;
        end
    end

    rob_commit_sel #(.CW(COMMIT_WIDTH)) u_sel (
        .valid_i    (s_valid),
        .ready_i    (s_ready),
        .store_i    (s_store),
        .exc_i      (s_exc),
        .take_o     (take),
        .n_o        (grp_n),
        .head_exc_o (head_exc)
    );

    // Commit and store-permit outputs; a store slot goes to the store buffer instead of cm_valid
    always_comb begin
        cm_valid  = '0;
        cm_rd     = '0;
        cm_data   = '0;
        cm_id     = '0;
        sb_permit = 1'b0;
        sb_id     = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (take[k]) begin
                if (ent_q[slot_idx[k]].is_store) begin
                    sb_permit = 1'b1;
                    sb_id     = slot_idx[k];
                end else begin
                    cm_valid[k] = 1'b1;
                    cm_rd[k*REG_INDEX_SIZE +: REG_INDEX_SIZE] = ent_q[slot_idx[k]].rd[REG_INDEX_SIZE-1:0];
                    cm_data[k*WORD_SIZE +: WORD_SIZE]         = ent_q[slot_idx[k]].data[WORD_SIZE-1:0];
                    cm_id[k*IW +: IW]                         = slot_idx[k];
                end
            end
        end
    end

    assign exception = head_exc;
    assign ex_pc     = head_exc ? ent_q[head_q].pc[WORD_SIZE-1:0]    : '0;
    assign ex_vaddr  = head_exc ? ent_q[head_q].vaddr[WORD_SIZE-1:0] : '0;
    assign ex_itlb   = head_exc & ent_q[head_q].itlb;

`ifdef ROB_BYPASS_EN
    // Operand forwarding straight from entry storage
    assign byp1_valid = ent_q[rs1_id].valid & ent_q[rs1_id].ready;
    assign byp2_valid = ent_q[rs2_id].valid & ent_q[rs2_id].ready;
    assign byp1_data  = ent_q[rs1_id].data[WORD_SIZE-1:0];
    assign byp2_data  = ent_q[rs2_id].data[WORD_SIZE-1:0];
`endif

    // Next state: writeback (lowest port last so it wins), free group, allocate, flush on exception
    always_comb begin
        logic [IW-1:0] wid;
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        wid    = '0;
        for (int p = WB_PORTS-1; p >= 0; p--) begin
            wid = wb_id[p*IW +: IW];
            if (wb_valid[p] && ent_q[wid].valid) begin
                ent_d[wid].ready = 1'b1;
                ent_d[wid].data  = ROB_WORD'(wb_data[p*WORD_SIZE +: WORD_SIZE]);
                ent_d[wid].exc   = wb_exc[p];
                ent_d[wid].itlb  = 1'b0;
                ent_d[wid].pc    = ROB_WORD'(wb_pc[p*WORD_SIZE +: WORD_SIZE]);
                ent_d[wid].vaddr = ROB_WORD'(wb_vaddr[p*WORD_SIZE +: WORD_SIZE]);
            end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (take[k]) ent_d[slot_idx[k]] = '0;
        end
        head_d = head_q + IW'(grp_n);
        if (alloc_acc) begin
            ent_d[tail_q].valid    = 1'b1;
            ent_d[tail_q].ready    = alloc_exc;
            ent_d[tail_q].is_store = alloc_is_store;
            ent_d[tail_q].exc      = alloc_exc;
            ent_d[tail_q].itlb     = alloc_exc;
            ent_d[tail_q].rd       = ROB_REG'(alloc_rd);
            ent_d[tail_q].data     = '0;
            ent_d[tail_q].pc       = ROB_WORD'(alloc_pc);
            ent_d[tail_q].vaddr    = '0;
            tail_d = tail_q + IW'(1);
        end
        cnt_d = cnt_q + (IW+1)'(alloc_acc) - (IW+1)'(grp_n);
        if (head_exc) begin
            for (int i = 0; i < N; i++) ent_d[i] = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) ent_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rob_mc.sv
// tb/tb_rob_mc.sv - scoreboard bench for rob_mc with directed vectors
module tb_rob_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid, alloc_is_store, alloc_exc;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc;
    logic [2:0]  alloc_id;
    logic        full;
    logic [2:0]  wb_valid, wb_exc;
    logic [8:0]  wb_id;
    logic [95:0] wb_data, wb_pc, wb_vaddr;
    logic [1:0]  cm_valid;
    logic [9:0]  cm_rd;
    logic [63:0] cm_data;
    logic [5:0]  cm_id;
    logic        sb_permit;
    logic [2:0]  sb_id;
    logic        exception, ex_itlb;
    logic [31:0] ex_pc, ex_vaddr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [2:0] id; logic [4:0] rd; logic [31:0] data; bit st; } exp_t;
    typedef struct { logic [31:0] pc; logic [31:0] vaddr; bit itlb; } exx_t;
    exp_t exp_q[$];
    exx_t exq[$];

    rob_mc dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store), .alloc_rd(alloc_rd),
        .alloc_exc(alloc_exc), .alloc_pc(alloc_pc), .alloc_id(alloc_id), .full(full),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_exc(wb_exc),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_data(cm_data), .cm_id(cm_id),
        .sb_permit(sb_permit), .sb_id(sb_id),
        .exception(exception), .ex_pc(ex_pc), .ex_vaddr(ex_vaddr), .ex_itlb(ex_itlb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb;
        wb_valid = '0; wb_exc = '0; wb_id = '0; wb_data = '0; wb_pc = '0; wb_vaddr = '0;
    endtask

    task automatic set_wb(input int p, input logic [2:0] id, input logic [31:0] data,
                          input bit exc, input logic [31:0] pc, input logic [31:0] va);
        wb_valid[p] = 1'b1;
        wb_exc[p]   = exc;
        wb_id[p*3 +: 3]     = id;
        wb_data[p*32 +: 32] = data;
        wb_pc[p*32 +: 32]   = pc;
        wb_vaddr[p*32 +: 32] = va;
    endtask

    task automatic alloc(input bit st, input logic [4:0] rd, input bit ex,
                         input logic [31:0] pc, input logic [2:0] exp_id);
        alloc_valid = 1'b1; alloc_is_store = st; alloc_rd = rd; alloc_exc = ex; alloc_pc = pc;
        #1 check("alloc_id", alloc_id, exp_id);
        tick;
        alloc_valid = 1'b0; alloc_is_store = 1'b0; alloc_exc = 1'b0;
    endtask

    task automatic push_c(input logic [2:0] id, input logic [4:0] rd, input logic [31:0] d, input bit st);
        exp_t e;
        e.id = id; e.rd = rd; e.data = d; e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic do_reset;
        check("queue_drained", 64'(exp_q.size() + exq.size()), 0);
        rst = 1'b0;
        tick;
        rst = 1'b1;
    endtask

    // Monitor: consume presented commits/stores in age order and exceptions against the scoreboard
    always @(negedge clk) begin : mon
        int   k;
        bit   sp;
        exp_t e;
        exx_t x;
        sp = sb_permit;
        k  = 0;
        for (int it = 0; it < 4; it++) begin
            while (k < 2 && !cm_valid[k]) k++;
            if (!sp && k >= 2) break;
            if (exp_q.size() == 0) begin
                check("unexpected_commit", 1, 0);
                break;
            end
            e = exp_q.pop_front();
            if (e.st) begin
                check("store_permit", sp, 1);
                check("store_id", sb_id, e.id);
                sp = 1'b0;
            end else if (k < 2) begin
                check("cm_id", cm_id[k*3 +: 3], e.id);
                check("cm_rd", cm_rd[k*5 +: 5], e.rd);
                check("cm_data", cm_data[k*32 +: 32], e.data);
                k++;
            end else begin
                check("commit_present", 0, 1);
            end
        end
        if (exception) begin
            if (exq.size() == 0) check("unexpected_exception", 1, 0);
            else begin
                x = exq.pop_front();
                check("ex_pc", ex_pc, x.pc);
                check("ex_vaddr", ex_vaddr, x.vaddr);
                check("ex_itlb", ex_itlb, x.itlb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exx_t x;
        rst = 1'b0; alloc_valid = 1'b0; alloc_is_store = 1'b0; alloc_exc = 1'b0;
        alloc_rd = '0; alloc_pc = '0;
        clear_wb;
        tick; tick;
        rst = 1'b1;
        #1;
        check("rst_full", full, 0);
        check("rst_cm_valid", cm_valid, 0);
        check("rst_sb_permit", sb_permit, 0);
        check("rst_exception", exception, 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_alloc_id_idle", alloc_id, 3'b111);
        check("rst_count", dut.cnt_q, 0);

        // Dual commit
        alloc(0, 5'd1, 0, 32'h100, 3'd0);
        alloc(0, 5'd2, 0, 32'h104, 3'd1);
        set_wb(0, 3'd0, 32'h11, 0, 32'h100, 0);
        set_wb(1, 3'd1, 32'h22, 0, 32'h104, 0);
        push_c(3'd0, 5'd1, 32'h11, 0);
        push_c(3'd1, 5'd2, 32'h22, 0);
        tick; clear_wb;
        check("dual_cm_valid", cm_valid, 2'b11);
        tick;
        check("dual_head", dut.head_q, 2);
        check("dual_count", dut.cnt_q, 0);

        // Store limit: one store per cycle
        do_reset;
        alloc(1, 5'd0, 0, 32'h200, 3'd0);
        alloc(1, 5'd0, 0, 32'h204, 3'd1);
        set_wb(0, 3'd0, 32'h0, 0, 32'h200, 32'h1000);
        set_wb(1, 3'd1, 32'h0, 0, 32'h204, 32'h1004);
        push_c(3'd0, 5'd0, 0, 1);
        push_c(3'd1, 5'd0, 0, 1);
        tick; clear_wb;
        check("st1_permit", sb_permit, 1);
        check("st1_id", sb_id, 0);
        check("st1_cm_valid", cm_valid, 0);
        tick;
        check("st2_permit", sb_permit, 1);
        check("st2_id", sb_id, 1);
        tick;
        check("st3_permit", sb_permit, 0);

        // Oldest exception wins over a younger decode fault
        do_reset;
        alloc(0, 5'd3, 0, 32'h300, 3'd0);
        alloc(0, 5'd4, 0, 32'h304, 3'd1);
        alloc(0, 5'd5, 0, 32'h308, 3'd2);
        alloc(0, 5'd6, 1, 32'h30C, 3'd3);
        set_wb(0, 3'd1, 32'h0, 1, 32'h304, 32'hBEEF0000);
        tick; clear_wb;
        check("exc_not_yet", exception, 0);
        set_wb(1, 3'd0, 32'h77, 0, 32'h300, 0);
        push_c(3'd0, 5'd3, 32'h77, 0);
        tick; clear_wb;
        check("exc_pre_commit", cm_valid, 2'b01);
        check("exc_pre_flag", exception, 0);
        x.pc = 32'h304; x.vaddr = 32'hBEEF0000; x.itlb = 0;
        exq.push_back(x);
        tick;
        check("exc_raised", exception, 1);
        check("exc_pc_direct", ex_pc, 32'h304);
        check("exc_itlb_direct", ex_itlb, 0);
        check("exc_no_commit", {cm_valid, sb_permit}, 0);
        tick;
        check("flush_count", dut.cnt_q, 0);
        check("flush_exception", exception, 0);

        // Writeback collision: lowest port wins
        do_reset;
        for (int i = 0; i < 5; i++) alloc(0, 5'(10 + i), 0, 32'h400 + 32'(4 * i), 3'(i));
        set_wb(0, 3'd0, 32'h1000, 0, 0, 0);
        set_wb(1, 3'd1, 32'h1001, 0, 0, 0);
        set_wb(2, 3'd2, 32'h1002, 0, 0, 0);
        push_c(3'd0, 5'd10, 32'h1000, 0);
        push_c(3'd1, 5'd11, 32'h1001, 0);
        push_c(3'd2, 5'd12, 32'h1002, 0);
        tick; clear_wb;
        set_wb(0, 3'd3, 32'h1003, 0, 0, 0);
        push_c(3'd3, 5'd13, 32'h1003, 0);
        tick; clear_wb;
        set_wb(0, 3'd4, 32'hA, 0, 0, 0);
        set_wb(2, 3'd4, 32'hB, 0, 0, 0);
        push_c(3'd4, 5'd14, 32'hA, 0);
        tick; clear_wb;
        tick; tick; tick;
        check("coll_count", dut.cnt_q, 0);

        // Writeback to an invalid entry is ignored
        set_wb(1, 3'd5, 32'hDEAD, 1, 32'h999, 32'h999);
        tick; clear_wb;
        check("inv_wb_exc", exception, 0);
        alloc(0, 5'd20, 0, 32'h414, 3'd5);
        check("inv_wb_not_ready", cm_valid, 0);
        check("inv_wb_exc2", exception, 0);
        set_wb(2, 3'd5, 32'h55, 0, 0, 0);
        push_c(3'd5, 5'd20, 32'h55, 0);
        tick; clear_wb;
        check("late_commit", cm_valid, 2'b01);
        tick;

        // Wrap and full
        do_reset;
        for (int i = 0; i < 8; i++) alloc(0, 5'(i + 1), 0, 32'h500 + 32'(4 * i), 3'(i));
        check("full_set", full, 1);
        check("full_count", dut.cnt_q, 8);
        alloc_valid = 1'b1;
        #1 check("full_alloc_id", alloc_id, 3'b111);
        set_wb(0, 3'd0, 32'h60, 0, 0, 0);
        set_wb(1, 3'd1, 32'h61, 0, 0, 0);
        push_c(3'd0, 5'd1, 32'h60, 0);
        push_c(3'd1, 5'd2, 32'h61, 0);
        tick; clear_wb;
        check("free_cycle_full", full, 1);
        check("free_cycle_alloc_id", alloc_id, 3'b111);
        tick;
        alloc_valid = 1'b0;
        check("after_free_count", dut.cnt_q, 6);
        alloc(0, 5'd9, 0, 32'h520, 3'd0);
        alloc(0, 5'd10, 0, 32'h524, 3'd1);
        check("wrap_tail", dut.tail_q, 2);
        check("wrap_count", dut.cnt_q, 8);
        check("wrap_full", full, 1);

        // Reset mid-operation overrides allocation and writeback
        do_reset;
        for (int i = 0; i < 5; i++) alloc(0, 5'(i), 0, 32'h600 + 32'(4 * i), 3'(i));
        set_wb(0, 3'd2, 32'h99, 0, 0, 0);
        tick; clear_wb;
        check("mid_no_commit", cm_valid, 0);
        rst = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd7; alloc_pc = 32'h700;
        set_wb(0, 3'd0, 32'h42, 0, 0, 0);
        tick;
        rst = 1'b1; alloc_valid = 1'b0; clear_wb;
        check("mid_count", dut.cnt_q, 0);
        check("mid_cm_valid", cm_valid, 0);
        check("mid_sb_permit", sb_permit, 0);
        check("mid_full", full, 0);
        alloc(0, 5'd7, 0, 32'h700, 3'd0);
        check("mid_count_after", dut.cnt_q, 1);
        tick;

        check("final_drained", 64'(exp_q.size() + exq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
